cdc_hs_rx: RTL and testbench
============================

CDC_HS_RX -- requirements
Module: cdc_hs_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the transferred data word.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-transfer counter.
REQ-003 SHALL have port rd_clk  input  1  receive-domain clock; the single clock of the block.
REQ-004 SHALL have port rd_reset  input  1  synchronous, active-high reset, sampled on rising rd_clk.
REQ-005 SHALL have port req_sync  input  1  sender request level, already two-flop synchronized into rd_clk.
REQ-006 SHALL have port data_in  input  DATA_W  sender data bus, unsynchronized, held stable by sender while req is high and until ack is observed.
REQ-007 SHALL have port ack  output  1  registered acknowledge level returned to the sender domain (sender synchronizes it).
REQ-008 SHALL have port out_valid  output  1  captured word available downstream.
REQ-009 SHALL have port out_data  output  DATA_W  captured word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-011 SHALL have port xfer_cnt  output  CNT_W  number of completed transfers.
REQ-012 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL implement a 4-phase receive FSM with states IDLE, HOLD, ACK.
REQ-014 SHALL, in IDLE with req_sync=1 at a rising edge, load out_data<=data_in, set out_valid=1 and go to HOLD (out_valid visible one cycle after req_sync first samples high).
REQ-015 SHALL, in IDLE with req_sync=0, stay in IDLE with ack=0 and out_valid=0.
REQ-016 SHALL, in HOLD, keep out_valid=1 and out_data unchanged until out_valid&&out_ready is sampled.
REQ-017 SHALL, on the HOLD handshake edge, clear out_valid, set ack=1, increment xfer_cnt by 1 modulo 2^CNT_W, and go to ACK.
REQ-018 SHALL, in ACK, hold ack=1 while req_sync=1; when req_sync=0 is sampled, clear ack and return to IDLE.
REQ-019 SHALL NOT accept a new word in the cycle ack falls; earliest new capture is the following IDLE edge.
REQ-020 SHALL set proto_err=1 if req_sync is sampled 0 while in HOLD; the held word is still delivered and the FSM proceeds normally.
REQ-021 SHALL keep proto_err set until rd_reset.
REQ-022 SHALL wrap xfer_cnt from 2^CNT_W-1 to 0 without flagging.
REQ-023 SHALL drive ack, out_valid, proto_err and xfer_cnt directly from flops (no combinational path from inputs).
REQ-024 SHALL NOT load out_data except on the IDLE->HOLD transition.

Reset
REQ-025 SHALL, on rd_reset=1 at a rising edge, force state IDLE, ack=0, out_valid=0, out_data=0, xfer_cnt=0, proto_err=0.
REQ-026 SHALL, on reset mid-transfer (HOLD or ACK), discard the held word without counting it; if req_sync is still 1 after reset release, treat it as a new request in IDLE.
REQ-027 SHALL give reset priority over all other events in the same cycle.

Structure
REQ-028 SHALL place the FSM state typedef (IDLE, HOLD, ACK) in shared package cdc_pkg.
REQ-029 SHALL have no sub-module; req synchronization is done externally by the existing two-flop synchronizer.

Verification
REQ-030 SHALL verify single transfer: data_in=8'hA5, req_sync 0->1, out_ready=1 -> out_valid high one cycle after req_sync, out_data=8'hA5, ack=1 next cycle, xfer_cnt=1; req_sync->0 -> ack=0 next cycle.
REQ-031 SHALL verify backpressure: out_ready=0 for 5 cycles after capture -> out_valid stays 1, out_data stable, ack stays 0; out_ready=1 -> ack rises next cycle.
REQ-032 SHALL verify protocol error: req_sync dropped during HOLD -> proto_err=1 sticky, word still delivered, xfer_cnt increments.
REQ-033 SHALL verify reset mid-HOLD: rd_reset pulse -> out_valid=0, ack=0, xfer_cnt unchanged from 0, with req_sync still high -> new capture after release.
REQ-034 SHALL verify wrap: CNT_W=2, 5 back-to-back transfers -> xfer_cnt sequence 1,2,3,0,1, proto_err=0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types for the clock-domain-crossing handshake receiver.
package cdc_pkg;

  // Receive-side 4-phase handshake states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StAck  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/cdc_hs_rx.sv
// Receive side of a 4-phase req/ack handshake. Captures the sender's word on the
// synchronized request, presents it downstream with valid/ready, then returns
// ack until the sender drops req. Counts completed transfers and flags a sender
// that drops req before the word has been consumed.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rd_reset,
  input  logic              req_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              proto_err
);

  rx_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // Next-state logic: every output is a registered copy of these values.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_sync) begin
          // data_in is stable while req is high, so sampling it here is safe.
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        // Sender released req before we acknowledged; still deliver the word.
        if (!req_sync) begin
          err_d = 1'b1;
        end
        // valid_q is always set in this state, so ready alone completes it.
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StAck;
        end
      end
      StAck: begin
        // Ack falls and we return to idle; a new capture waits for the next edge.
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any in-flight transfer.
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Bench for cdc_hs_rx: directed handshake sequences on a default-width instance,
// with a scoreboard monitor checking every delivered word, plus a 2-bit counter
// instance for wrap-around.
module tb_cdc_hs_rx;

  logic       clk;
  logic       rd_reset;
  logic       req_sync;
  logic [7:0] data_in;
  logic       out_ready;
  logic       ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic [15:0] xfer_cnt;
  logic       proto_err;

  logic       w_req;
  logic [7:0] w_data;
  logic       w_ack;
  logic       w_valid;
  logic [7:0] w_out_data;
  logic [1:0] w_cnt;
  logic       w_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  logic [15:0] exp_cnt = '0;

  cdc_hs_rx #(.DATA_W(8), .CNT_W(16)) dut (
    .rd_clk    (clk),
    .rd_reset  (rd_reset),
    .req_sync  (req_sync),
    .data_in   (data_in),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err)
  );

  cdc_hs_rx #(.DATA_W(8), .CNT_W(2)) dut_w (
    .rd_clk    (clk),
    .rd_reset  (rd_reset),
    .req_sync  (w_req),
    .data_in   (w_data),
    .ack       (w_ack),
    .out_valid (w_valid),
    .out_data  (w_out_data),
    .out_ready (1'b1),
    .xfer_cnt  (w_cnt),
    .proto_err (w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted word is popped and compared, and the
  // following cycle must show ack and the bumped transfer count.
  initial begin
    logic       pend;
    logic [7:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_reset) begin
        exp_cnt = '0;
        pend    = 1'b0;
      end else begin
        if (pend) begin
          chk("mon_ack", 32'(ack), 32'd1);
          chk("mon_cnt", 32'(xfer_cnt), 32'(exp_cnt));
          pend = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("mon_sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("mon_data", 32'(out_data), 32'(e));
            exp_cnt = exp_cnt + 16'd1;
            pend    = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] wrap_exp[5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rd_reset  = 1'b1;
    req_sync  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    w_req     = 1'b0;
    w_data    = 8'h00;
    step();
    step();
    rd_reset = 1'b0;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single transfer with downstream always ready.
    data_in = 8'hA5; out_ready = 1'b1; req_sync = 1'b1; sb.push_back(8'hA5);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_ack_lo", 32'(ack), 32'd0);
    step();
    chk("t1_ack_hi", 32'(ack), 32'd1);
    chk("t1_valid_lo", 32'(out_valid), 32'd0);
    chk("t1_cnt", 32'(xfer_cnt), 32'd1);
    step();
    chk("t1_ack_hold", 32'(ack), 32'd1);
    req_sync = 1'b0;
    step();
    chk("t1_ack_fall", 32'(ack), 32'd0);

    // Backpressure; data_in changes after capture and must not be reloaded.
    out_ready = 1'b0; data_in = 8'h3C; req_sync = 1'b1; sb.push_back(8'h3C);
    step();
    data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_ack_hi", 32'(ack), 32'd1);
    chk("bp_cnt", 32'(xfer_cnt), 32'd2);
    req_sync = 1'b0;
    step();
    chk("bp_ack_fall", 32'(ack), 32'd0);
    chk("bp_err", 32'(proto_err), 32'd0);

    // Sender drops req while the word is still held.
    out_ready = 1'b0; data_in = 8'h5A; req_sync = 1'b1; sb.push_back(8'h5A);
    step();
    req_sync = 1'b0;
    step();
    chk("pe_err", 32'(proto_err), 32'd1);
    chk("pe_valid", 32'(out_valid), 32'd1);
    chk("pe_data", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    step();
    chk("pe_ack", 32'(ack), 32'd1);
    chk("pe_cnt", 32'(xfer_cnt), 32'd3);
    step();
    chk("pe_ack_fall", 32'(ack), 32'd0);
    chk("pe_err_sticky", 32'(proto_err), 32'd1);

    // Reset while holding a word; req stays high so it is recaptured after.
    out_ready = 1'b0; data_in = 8'hC3; req_sync = 1'b1; sb.push_back(8'hC3);
    step();
    chk("rh_valid_pre", 32'(out_valid), 32'd1);
    rd_reset = 1'b1;
    step();
    void'(sb.pop_back());
    chk("rh_valid", 32'(out_valid), 32'd0);
    chk("rh_ack", 32'(ack), 32'd0);
    chk("rh_cnt", 32'(xfer_cnt), 32'd0);
    chk("rh_err", 32'(proto_err), 32'd0);
    chk("rh_data", 32'(out_data), 32'd0);
    rd_reset = 1'b0; data_in = 8'h7E; sb.push_back(8'h7E);
    step();
    chk("rh_recap_valid", 32'(out_valid), 32'd1);
    chk("rh_recap_data", 32'(out_data), 32'h7E);
    out_ready = 1'b1;
    step();
    chk("rh_ack", 32'(ack), 32'd1);
    chk("rh_cnt_after", 32'(xfer_cnt), 32'd1);
    req_sync = 1'b0;
    step();
    chk("rh_ack_fall", 32'(ack), 32'd0);

    // 2-bit counter: back-to-back transfers, req re-raised right as ack falls.
    for (int i = 0; i < 5; i++) begin
      w_data = 8'(8'h10 + i);
      w_req  = 1'b1;
      step();
      chk("wr_valid", 32'(w_valid), 32'd1);
      chk("wr_data", 32'(w_out_data), 32'(8'h10 + i));
      step();
      chk("wr_ack", 32'(w_ack), 32'd1);
      chk("wr_cnt", 32'(w_cnt), 32'(wrap_exp[i]));
      w_req = 1'b0;
      step();
      chk("wr_ack_fall", 32'(w_ack), 32'd0);
      chk("wr_no_capture", 32'(w_valid), 32'd0);
    end
    chk("wr_err", 32'(w_err), 32'd0);

    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
